axi_wr_arbiter: RTL

//  Write-path scheduler for the AXI interconnect. Shares one slave write port between two masters (M0, M1).

---
 rtl/axi_wr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin write-path scheduler sharing one AXI slave
// write port between two masters (M0, M1). A grant is taken on the AW
// request and held through the W last beat until the B handshake.
// Optional watchdog: define AXI_WR_TIMEOUT_EN to build it. When it is not
// defined, timeout_err is tied low and a burst may wait indefinitely.
module axi_wr_arbiter #(
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = 200
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       AWVALID_M0,
  input  logic       AWVALID_M1,
  output logic       AWREADY_M0,
  output logic       AWREADY_M1,
  output logic       AWVALID_S,
  input  logic       AWREADY_S,
  input  logic       WVALID_S,
  input  logic       WREADY_S,
  input  logic       WLAST_S,
  input  logic       BVALID_S,
  input  logic       BREADY_S,
  output logic [1:0] grant,
  output logic       w_en,
  output logic       AWHandShake,
  output logic       BHandShake,
  output logic       timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] grant_nxt;
  logic       last;       // 1'b1: M1 was the most recent owner
  logic       last_nxt;
  logic       in_addr;
  logic       in_burst;   // DATA or RESP, the phases the watchdog covers
  logic       w_last_hs;
  logic       timeout_hit;

  assign in_addr  = (state == ST_ADDR);
  assign in_burst = (state == ST_DATA) || (state == ST_RESP);

  // Only the granted master's request reaches the slave, and only in ADDR.
  assign AWVALID_S   = in_addr && ((grant[0] && AWVALID_M0) || (grant[1] && AWVALID_M1));
  assign AWREADY_M0  = in_addr && AWREADY_S && grant[0];
  assign AWREADY_M1  = in_addr && AWREADY_S && grant[1];
  assign AWHandShake = AWVALID_S && AWREADY_S;
  assign w_en        = (state == ST_DATA);
  assign w_last_hs   = WVALID_S && WREADY_S && WLAST_S;
  assign BHandShake  = (state == ST_RESP) && BVALID_S && BREADY_S;
  assign timeout_err = timeout_hit;

`ifdef AXI_WR_TIMEOUT_EN
  logic [TO_W-1:0] wd_cnt;

  assign timeout_hit = in_burst && (wd_cnt == TO_W'(TO_LIMIT - 1));

  // Watchdog: counts burst cycles, clears outside a burst and on expiry.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_cnt <= '0;
    end else if (in_burst && !timeout_hit) begin
      wd_cnt <= wd_cnt + TO_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, next-owner and round-robin history selection.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (AWVALID_M0 && AWVALID_M1) begin
          // Tie: the master that did not own the port last time wins.
          grant_nxt = last ? 2'b01 : 2'b10;
          state_nxt = ST_ADDR;
        end else if (AWVALID_M0) begin
          grant_nxt = 2'b01;
          state_nxt = ST_ADDR;
        end else if (AWVALID_M1) begin
          grant_nxt = 2'b10;
          state_nxt = ST_ADDR;
        end else begin
          grant_nxt = 2'b00;
          state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // Grant is never revoked here; wait for the address handshake.
        if (AWHandShake) begin
          state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (timeout_hit) begin
          state_nxt = ST_IDLE;
          grant_nxt = 2'b00;
          last_nxt  = grant[1];
        end else if (w_last_hs) begin
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_RESP: begin
        if (timeout_hit || BHandShake) begin
          state_nxt = ST_IDLE;
          grant_nxt = 2'b00;
          last_nxt  = grant[1];
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
        last_nxt  = last;
      end
    endcase
  end

  // Registered phase, owner and history; reset makes M0 win the first tie.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

endmodule
